flog_arbiter: RTL
=================

// Module: flog_arbiter
// PURPOSE
//  Shares one non-pipelined bfloat16 log2 core (FLOG top_top) between N requesters.
//  Picks one pending request round-robin, launches it on the core, waits for the core result,
//  and returns the result tagged with the requester index.
//  A watchdog aborts a core operation that never completes.
//  Sits between the requester fabric and the FLOG core; one operation in flight at a time.
// PARAMETERS
//  N_REQ      4    number of requester channels (>=2)
//  EXP        8    bfloat16 exponent width
//  MAN        7    bfloat16 fraction width
//  TIMEOUT    64   max cycles waited for core valid before abort (>=2)
//  ID_W       $clog2(N_REQ)  width of requester index
// PORTS
//  clk          in   1              clock, all logic on rising edge
//  rst          in   1              asynchronous reset, active-high
//  req_valid_i  in   N_REQ          per-requester operand valid
//  req_data_i   in   N_REQ*16       packed operands, {sign,exp,frac}; requester k at [16k+15:16k]
//  req_ready_o  out  N_REQ          one-hot accept strobe, at most one bit high
//  core_sign_o  out  1              operand sign to core
//  core_exp_o   out  EXP            operand exponent to core
//  core_frac_o  out  MAN            operand fraction to core
//  core_valid_o out  1              start strobe to core (input_valid)
//  core_s_i     in   1              core result sign
//  core_e_i     in   EXP            core result exponent
//  core_f_i     in   MAN            core result fraction
//  core_valid_i in   1              core result valid
//  rsp_valid_o  out  1              response valid
//  rsp_id_o     out  ID_W           index of requester owning the response
//  rsp_data_o   out  16             result {s,e,f}
//  rsp_err_o    out  1              1 = operation aborted by watchdog
//  rsp_ready_i  in   1              response accepted
// BEHAVIOUR
//  Reset: state=IDLE, rr_ptr=0, timer=0, all outputs 0 (operand regs 0, rsp_* 0, req_ready_o 0).
//  Reset mid-operation discards the in-flight op; no response is produced for it.
//  Arbitration: the winner is the first set req_valid_i bit scanning from rr_ptr upward, wrapping N_REQ-1->0.
//  On grant, rr_ptr <= winner+1 (wraps).
//  FSM:
//   IDLE  : req_ready_o[winner]=1 combinationally when any req_valid_i set; handshake = valid&ready;
//           latch operand + id -> ISSUE. No request -> stay.
//   ISSUE : core_valid_o=1 for exactly this cycle; timer<=0 -> WAIT.
//   WAIT  : core_valid_i=1 -> latch {core_s_i,core_e_i,core_f_i}, rsp_err=0 -> RESP.
//           Else timer++; timer==TIMEOUT-1 -> rsp_data=16'h7FC0 (qNaN), rsp_err=1 -> RESP.
//   RESP  : rsp_valid_o=1, rsp_* stable until rsp_valid_o&rsp_ready_i; then -> IDLE (same edge).
//  core_sign/exp/frac_o hold the latched operand from ISSUE until the next grant.
//  core_valid_i outside WAIT (late result after timeout) is ignored.
//  req_ready_o is 0 in ISSUE/WAIT/RESP: back-pressure, requesters hold valid+data.
//  Latency: accept at cycle t -> core_valid_o at t+1 -> rsp_valid_o the cycle after core_valid_i.
//   With rsp_ready_i=1, the next grant is possible the cycle after the rsp handshake.
//  core_valid_i in the same cycle the timer expires: the result wins, err=0.
//  req_valid_i dropped without handshake: ignored, no state change.
// TESTING
//  Bench uses a stub core: result = operand ^ 16'h00FF, core_valid_i L cycles after core_valid_o.
//  1 single req: req0 data 16'h47FA, L=5 -> core ops 0/143/7'h7A; rsp id0 data 16'h4705 err0,
//    rsp_valid 6 cycles after core_valid_o.
//  2 all 4 valid continuously, rsp_ready_i=1 -> grant order 0,1,2,3,0; exactly one req_ready bit per grant.
//  3 rsp_ready_i low 10 cycles in RESP -> rsp_* stable, no req_ready_o, no core_valid_o.
//  4 stub never answers -> rsp err1 data 16'h7FC0 exactly TIMEOUT cycles after entering WAIT;
//    a late core_valid_i is ignored.
//  5 rst pulsed in WAIT -> all outputs 0 next cycle, rr_ptr=0, no response; a new req1 is served normally.
//  6 core_valid_i on the final timeout cycle -> rsp err0 with core data.

Source files
------------

// File: rtl/flog_arbiter.sv
// Round-robin front end that shares one non-pipelined bfloat16 log2 core between N_REQ requesters.
// One operation is in flight at a time; a watchdog turns a silent core into a qNaN error response.
module flog_arbiter #(
  parameter int N_REQ   = 4,
  parameter int EXP     = 8,
  parameter int MAN     = 7,
  parameter int TIMEOUT = 64,
  parameter int ID_W    = $clog2(N_REQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_REQ-1:0]  req_valid_i,
  input  logic [N_REQ*16-1:0] req_data_i,
  output logic [N_REQ-1:0]  req_ready_o,
  output logic              core_sign_o,
  output logic [EXP-1:0]    core_exp_o,
  output logic [MAN-1:0]    core_frac_o,
  output logic              core_valid_o,
  input  logic              core_s_i,
  input  logic [EXP-1:0]    core_e_i,
  input  logic [MAN-1:0]    core_f_i,
  input  logic              core_valid_i,
  output logic              rsp_valid_o,
  output logic [ID_W-1:0]   rsp_id_o,
  output logic [15:0]       rsp_data_o,
  output logic              rsp_err_o,
  input  logic              rsp_ready_i
);

  localparam int          TW       = $clog2(TIMEOUT);
  localparam logic [15:0] QNAN     = 16'h7FC0;
  localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state_q;
  logic [ID_W-1:0] rr_q;
  logic [ID_W-1:0] id_q;
  logic [15:0]     op_q;
  logic            core_valid_q;
  logic [TW-1:0]   timer_q;
  logic            rsp_valid_q;
  logic [ID_W-1:0] rsp_id_q;
  logic [15:0]     rsp_data_q;
  logic            rsp_err_q;

  logic [15:0]       data_arr [N_REQ];
  logic [2*N_REQ-1:0] dbl_valid;
  logic [N_REQ-1:0]  rot_valid;
  logic              grant_found;
  logic [ID_W-1:0]   grant_off;
  logic [ID_W:0]     grant_sum;
  logic [ID_W-1:0]   grant_id;
  logic [ID_W-1:0]   rr_d;
  logic              accept;

  // Unpack the operand bus so the winner's operand is a plain array read.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign data_arr[gi] = req_data_i[16*gi +: 16];
  end

  // Rotate the request vector so bit 0 is the rr_ptr position, then take the lowest set bit.
  always_comb begin
    dbl_valid   = {req_valid_i, req_valid_i} >> rr_q;
    rot_valid   = dbl_valid[N_REQ-1:0];
    grant_found = 1'b0;
    grant_off   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!grant_found && rot_valid[i]) begin
        grant_found = 1'b1;
        grant_off   = ID_W'(i);
      end
    end
    grant_sum = {1'b0, rr_q} + {1'b0, grant_off};
    if (grant_sum >= (ID_W+1)'(N_REQ)) begin
      grant_sum = grant_sum - (ID_W+1)'(N_REQ);
    end
    grant_id = grant_sum[ID_W-1:0];
    rr_d     = (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
  end

  assign accept = (state_q == IDLE) && grant_found && !rst;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ready
    assign req_ready_o[gi] = accept && (grant_id == ID_W'(gi));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      rr_q         <= '0;
      id_q         <= '0;
      op_q         <= '0;
      core_valid_q <= 1'b0;
      timer_q      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_found) begin
            op_q         <= data_arr[grant_id];
            id_q         <= grant_id;
            rr_q         <= rr_d;
            core_valid_q <= 1'b1;
            state_q      <= ISSUE;
          end
        end
        ISSUE: begin
          core_valid_q <= 1'b0;
          timer_q      <= '0;
          state_q      <= WAIT;
        end
        WAIT: begin
          // A result arriving on the last watchdog cycle still wins over the abort.
          if (core_valid_i) begin
            rsp_data_q  <= {core_s_i, core_e_i, core_f_i};
            rsp_err_q   <= 1'b0;
            rsp_id_q    <= id_q;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else if (timer_q == TMR_LAST) begin
            rsp_data_q  <= QNAN;
            rsp_err_q   <= 1'b1;
            rsp_id_q    <= id_q;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign core_sign_o  = op_q[15];
  assign core_exp_o   = op_q[14 -: EXP];
  assign core_frac_o  = op_q[MAN-1:0];
  assign core_valid_o = core_valid_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_id_o     = rsp_id_q;
  assign rsp_data_o   = rsp_data_q;
  assign rsp_err_o    = rsp_err_q;

endmodule
